core_alu_arb: RTL and testbench

Two-requester arbiter and sequencer for the shared registered integer ALU (`core_alu`). It accepts operation requests from requester 0 (execute stage) and requester 1 (branch/address unit) over valid/ready handshakes, and grants them round-robin. It drives the ALU's one-hot operation strobes and operands, and returns the ALU result to the granted requester over a per-requester response handshake. One operation is in flight at a time.

---
 rtl/core_alu_pkg.sv | 50 +++++
 rtl/core_alu_opdec.sv | 15 +
 rtl/core_alu_arb.sv | 170 +++++++++++++++++
 tb/tb_core_alu_arb.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_alu_pkg.sv
// Shared encodings for the ALU arbiter: operation codes, strobe count and sequencer states.
package core_alu_pkg;

    localparam int unsigned OPW         = 6;
    localparam int unsigned NUM_STROBES = 33;

    typedef enum logic [OPW-1:0] {
        NONE  = 6'd0,
        ADDI  = 6'd1,
        SLTI  = 6'd2,
        SLTIU = 6'd3,
        XORI  = 6'd4,
        ORI   = 6'd5,
        ANDI  = 6'd6,
        SLLI  = 6'd7,
        SRLI  = 6'd8,
        SRAI  = 6'd9,
        ADD   = 6'd10,
        SUB   = 6'd11,
        SLL   = 6'd12,
        SLT   = 6'd13,
        SLTU  = 6'd14,
        XOR   = 6'd15,
        SRL   = 6'd16,
        SRA   = 6'd17,
        OR    = 6'd18,
        AND   = 6'd19,
        BEQ   = 6'd20,
        BNE   = 6'd21,
        BLT   = 6'd22,
        BGE   = 6'd23,
        BLTU  = 6'd24,
        BGEU  = 6'd25,
        LB    = 6'd26,
        LH    = 6'd27,
        LW    = 6'd28,
        LBU   = 6'd29,
        LHU   = 6'd30,
        SB    = 6'd31,
        SH    = 6'd32,
        SW    = 6'd33
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/core_alu_opdec.sv
// Encoded ALU op to one-hot strobes; bit k is set for op code k+1, unknown codes give no strobe.
module core_alu_opdec
    import core_alu_pkg::*;
#(
    parameter int unsigned OPW = core_alu_pkg::OPW
) (
    input  logic [OPW-1:0]         op,
    output logic [NUM_STROBES-1:0] strobes
);

    for (genvar g = 0; g < NUM_STROBES; g++) begin : g_dec
        assign strobes[g] = (op == OPW'(g + 1));
    end

endmodule

// File: rtl/core_alu_arb.sv
// Round-robin two-requester arbiter and one-op-in-flight sequencer for the shared registered ALU.
module core_alu_arb
    import core_alu_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned OPW  = core_alu_pkg::OPW
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            FLUSH,
    input  logic            REQ0_VALID,
    output logic            REQ0_READY,
    input  logic [OPW-1:0]  REQ0_OP,
    input  logic [XLEN-1:0] REQ0_RS1,
    input  logic [XLEN-1:0] REQ0_RS2,
    input  logic [XLEN-1:0] REQ0_IMM,
    input  logic            REQ1_VALID,
    output logic            REQ1_READY,
    input  logic [OPW-1:0]  REQ1_OP,
    input  logic [XLEN-1:0] REQ1_RS1,
    input  logic [XLEN-1:0] REQ1_RS2,
    input  logic [XLEN-1:0] REQ1_IMM,
    output logic            RSP0_VALID,
    input  logic            RSP0_READY,
    output logic            RSP1_VALID,
    input  logic            RSP1_READY,
    output logic [XLEN-1:0] RSP_RESULT,
    output logic            ALU_I_ADDI,
    output logic            ALU_I_SLTI,
    output logic            ALU_I_SLTIU,
    output logic            ALU_I_XORI,
    output logic            ALU_I_ORI,
    output logic            ALU_I_ANDI,
    output logic            ALU_I_SLLI,
    output logic            ALU_I_SRLI,
    output logic            ALU_I_SRAI,
    output logic            ALU_I_ADD,
    output logic            ALU_I_SUB,
    output logic            ALU_I_SLL,
    output logic            ALU_I_SLT,
    output logic            ALU_I_SLTU,
    output logic            ALU_I_XOR,
    output logic            ALU_I_SRL,
    output logic            ALU_I_SRA,
    output logic            ALU_I_OR,
    output logic            ALU_I_AND,
    output logic            ALU_I_BEQ,
    output logic            ALU_I_BNE,
    output logic            ALU_I_BLT,
    output logic            ALU_I_BGE,
    output logic            ALU_I_BLTU,
    output logic            ALU_I_BGEU,
    output logic            ALU_I_LB,
    output logic            ALU_I_LH,
    output logic            ALU_I_LW,
    output logic            ALU_I_LBU,
    output logic            ALU_I_LHU,
    output logic            ALU_I_SB,
    output logic            ALU_I_SH,
    output logic            ALU_I_SW,
    output logic [XLEN-1:0] ALU_RS1,
    output logic [XLEN-1:0] ALU_RS2,
    output logic [XLEN-1:0] ALU_IMM,
    input  logic [XLEN-1:0] ALU_RESULT
);

    arb_state_e      state_q;
    logic [OPW-1:0]  op_q;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] rs2_q;
    logic [XLEN-1:0] imm_q;
    logic            gnt_q;
    logic            prio_q;

    logic            rsp_ready_g;
    logic            can_accept;
    logic            accept;
    logic            sel;
    logic [NUM_STROBES-1:0] dec;
    logic [NUM_STROBES-1:0] strb;

    // A completing response frees the ALU in the same cycle, so RESP arbitrates like IDLE.
    assign rsp_ready_g = gnt_q ? RSP1_READY : RSP0_READY;
    assign can_accept  = !FLUSH && ((state_q == ST_IDLE) ||
                                    ((state_q == ST_RESP) && rsp_ready_g));
    assign sel         = (REQ0_VALID && REQ1_VALID) ? prio_q : REQ1_VALID;
    assign accept      = can_accept && (REQ0_VALID || REQ1_VALID);

    assign REQ0_READY  = accept && !sel;
    assign REQ1_READY  = accept && sel;

    assign RSP0_VALID  = (state_q == ST_RESP) && !FLUSH && !gnt_q;
    assign RSP1_VALID  = (state_q == ST_RESP) && !FLUSH && gnt_q;
    assign RSP_RESULT  = (state_q == ST_RESP) ? ALU_RESULT : '0;

    assign ALU_RS1     = rs1_q;
    assign ALU_RS2     = rs2_q;
    assign ALU_IMM     = imm_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
            gnt_q   <= 1'b0;
            prio_q  <= 1'b0;
        end else if (FLUSH) begin
            state_q <= ST_IDLE;
        end else if (accept) begin
            op_q    <= sel ? REQ1_OP  : REQ0_OP;
            rs1_q   <= sel ? REQ1_RS1 : REQ0_RS1;
            rs2_q   <= sel ? REQ1_RS2 : REQ0_RS2;
            imm_q   <= sel ? REQ1_IMM : REQ0_IMM;
            gnt_q   <= sel;
            prio_q  <= !sel;
            state_q <= ST_EXEC;
        end else begin
            case (state_q)
                ST_EXEC: state_q <= ST_RESP;
                ST_RESP: if (rsp_ready_g) state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    core_alu_opdec #(.OPW(OPW)) u_opdec (
        .op      (op_q),
        .strobes (dec)
    );

    // Strobes stay up through RESP so the registered ALU output does not move.
    assign strb = (state_q == ST_IDLE) ? '0 : dec;

    assign ALU_I_ADDI  = strb[0];
    assign ALU_I_SLTI  = strb[1];
    assign ALU_I_SLTIU = strb[2];
    assign ALU_I_XORI  = strb[3];
    assign ALU_I_ORI   = strb[4];
    assign ALU_I_ANDI  = strb[5];
    assign ALU_I_SLLI  = strb[6];
    assign ALU_I_SRLI  = strb[7];
    assign ALU_I_SRAI  = strb[8];
    assign ALU_I_ADD   = strb[9];
    assign ALU_I_SUB   = strb[10];
    assign ALU_I_SLL   = strb[11];
    assign ALU_I_SLT   = strb[12];
    assign ALU_I_SLTU  = strb[13];
    assign ALU_I_XOR   = strb[14];
    assign ALU_I_SRL   = strb[15];
    assign ALU_I_SRA   = strb[16];
    assign ALU_I_OR    = strb[17];
    assign ALU_I_AND   = strb[18];
    assign ALU_I_BEQ   = strb[19];
    assign ALU_I_BNE   = strb[20];
    assign ALU_I_BLT   = strb[21];
    assign ALU_I_BGE   = strb[22];
    assign ALU_I_BLTU  = strb[23];
    assign ALU_I_BGEU  = strb[24];
    assign ALU_I_LB    = strb[25];
    assign ALU_I_LH    = strb[26];
    assign ALU_I_LW    = strb[27];
    assign ALU_I_LBU   = strb[28];
    assign ALU_I_LHU   = strb[29];
    assign ALU_I_SB    = strb[30];
    assign ALU_I_SH    = strb[31];
    assign ALU_I_SW    = strb[32];

endmodule

// File: tb/tb_core_alu_arb.sv
// Directed bench for core_alu_arb: vector table for single ops plus contention, backpressure, flush and reset sequences.
module tb_core_alu_arb;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        FLUSH = 1'b0;
    logic        REQ0_VALID = 1'b0, REQ1_VALID = 1'b0;
    logic        REQ0_READY, REQ1_READY;
    logic [5:0]  REQ0_OP = '0, REQ1_OP = '0;
    logic [31:0] REQ0_RS1 = '0, REQ0_RS2 = '0, REQ0_IMM = '0;
    logic [31:0] REQ1_RS1 = '0, REQ1_RS2 = '0, REQ1_IMM = '0;
    logic        RSP0_VALID, RSP1_VALID;
    logic        RSP0_READY = 1'b0, RSP1_READY = 1'b0;
    logic [31:0] RSP_RESULT;
    logic        ALU_I_ADDI, ALU_I_SLTI, ALU_I_SLTIU, ALU_I_XORI, ALU_I_ORI, ALU_I_ANDI;
    logic        ALU_I_SLLI, ALU_I_SRLI, ALU_I_SRAI, ALU_I_ADD, ALU_I_SUB, ALU_I_SLL;
    logic        ALU_I_SLT, ALU_I_SLTU, ALU_I_XOR, ALU_I_SRL, ALU_I_SRA, ALU_I_OR, ALU_I_AND;
    logic        ALU_I_BEQ, ALU_I_BNE, ALU_I_BLT, ALU_I_BGE, ALU_I_BLTU, ALU_I_BGEU;
    logic        ALU_I_LB, ALU_I_LH, ALU_I_LW, ALU_I_LBU, ALU_I_LHU, ALU_I_SB, ALU_I_SH, ALU_I_SW;
    logic [31:0] ALU_RS1, ALU_RS2, ALU_IMM;
    logic [31:0] ALU_RESULT = '0;
    logic [32:0] strb;

    int n_vec = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    core_alu_arb #(.XLEN(32), .OPW(6)) dut (
        .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH),
        .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_OP(REQ0_OP),
        .REQ0_RS1(REQ0_RS1), .REQ0_RS2(REQ0_RS2), .REQ0_IMM(REQ0_IMM),
        .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_OP(REQ1_OP),
        .REQ1_RS1(REQ1_RS1), .REQ1_RS2(REQ1_RS2), .REQ1_IMM(REQ1_IMM),
        .RSP0_VALID(RSP0_VALID), .RSP0_READY(RSP0_READY),
        .RSP1_VALID(RSP1_VALID), .RSP1_READY(RSP1_READY),
        .RSP_RESULT(RSP_RESULT),
        .ALU_I_ADDI(ALU_I_ADDI), .ALU_I_SLTI(ALU_I_SLTI), .ALU_I_SLTIU(ALU_I_SLTIU),
        .ALU_I_XORI(ALU_I_XORI), .ALU_I_ORI(ALU_I_ORI), .ALU_I_ANDI(ALU_I_ANDI),
        .ALU_I_SLLI(ALU_I_SLLI), .ALU_I_SRLI(ALU_I_SRLI), .ALU_I_SRAI(ALU_I_SRAI),
        .ALU_I_ADD(ALU_I_ADD), .ALU_I_SUB(ALU_I_SUB), .ALU_I_SLL(ALU_I_SLL),
        .ALU_I_SLT(ALU_I_SLT), .ALU_I_SLTU(ALU_I_SLTU), .ALU_I_XOR(ALU_I_XOR),
        .ALU_I_SRL(ALU_I_SRL), .ALU_I_SRA(ALU_I_SRA), .ALU_I_OR(ALU_I_OR),
        .ALU_I_AND(ALU_I_AND), .ALU_I_BEQ(ALU_I_BEQ), .ALU_I_BNE(ALU_I_BNE),
        .ALU_I_BLT(ALU_I_BLT), .ALU_I_BGE(ALU_I_BGE), .ALU_I_BLTU(ALU_I_BLTU),
        .ALU_I_BGEU(ALU_I_BGEU), .ALU_I_LB(ALU_I_LB), .ALU_I_LH(ALU_I_LH),
        .ALU_I_LW(ALU_I_LW), .ALU_I_LBU(ALU_I_LBU), .ALU_I_LHU(ALU_I_LHU),
        .ALU_I_SB(ALU_I_SB), .ALU_I_SH(ALU_I_SH), .ALU_I_SW(ALU_I_SW),
        .ALU_RS1(ALU_RS1), .ALU_RS2(ALU_RS2), .ALU_IMM(ALU_IMM),
        .ALU_RESULT(ALU_RESULT)
    );

    assign strb = {ALU_I_SW, ALU_I_SH, ALU_I_SB, ALU_I_LHU, ALU_I_LBU, ALU_I_LW, ALU_I_LH,
                   ALU_I_LB, ALU_I_BGEU, ALU_I_BLTU, ALU_I_BGE, ALU_I_BLT, ALU_I_BNE,
                   ALU_I_BEQ, ALU_I_AND, ALU_I_OR, ALU_I_SRA, ALU_I_SRL, ALU_I_XOR,
                   ALU_I_SLTU, ALU_I_SLT, ALU_I_SLL, ALU_I_SUB, ALU_I_ADD, ALU_I_SRAI,
                   ALU_I_SRLI, ALU_I_SLLI, ALU_I_ANDI, ALU_I_ORI, ALU_I_XORI, ALU_I_SLTIU,
                   ALU_I_SLTI, ALU_I_ADDI};

    // Minimal registered ALU stand-in covering the ops this bench issues; others return 0.
    always @(posedge CLK) begin
        if (ALU_I_ADD)       ALU_RESULT <= ALU_RS1 + ALU_RS2;
        else if (ALU_I_SUB)  ALU_RESULT <= ALU_RS1 - ALU_RS2;
        else if (ALU_I_ADDI) ALU_RESULT <= ALU_RS1 + ALU_IMM;
        else if (ALU_I_SLTI) ALU_RESULT <= {31'd0, $signed(ALU_RS1) < $signed(ALU_IMM)};
        else if (ALU_I_XOR)  ALU_RESULT <= ALU_RS1 ^ ALU_RS2;
        else                 ALU_RESULT <= 32'd0;
    end

    typedef struct {
        logic        req;
        logic [5:0]  op;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] res;
        logic [32:0] strb;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic drive_req(input logic r, input logic [5:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] i);
        if (r) begin
            REQ1_VALID = 1'b1; REQ1_OP = op; REQ1_RS1 = a; REQ1_RS2 = b; REQ1_IMM = i;
        end else begin
            REQ0_VALID = 1'b1; REQ0_OP = op; REQ0_RS1 = a; REQ0_RS2 = b; REQ0_IMM = i;
        end
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge CLK);
        drive_req(v.req, v.op, v.rs1, v.rs2, v.imm);
        #1;
        check("accept_ready", {REQ1_READY, REQ0_READY}, v.req ? 2'b10 : 2'b01);
        @(negedge CLK);
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        #1;
        check("exec_strobes", strb, v.strb);
        check("exec_rs1", ALU_RS1, v.rs1);
        check("exec_no_rsp", {RSP1_VALID, RSP0_VALID}, 2'b00);
        @(negedge CLK);
        #1;
        check("resp_valid", {RSP1_VALID, RSP0_VALID}, v.req ? 2'b10 : 2'b01);
        check("resp_result", RSP_RESULT, v.res);
        check("resp_strobes_held", strb, v.strb);
        if (v.req) RSP1_READY = 1'b1; else RSP0_READY = 1'b1;
        @(negedge CLK);
        RSP0_READY = 1'b0; RSP1_READY = 1'b0;
        #1;
        check("idle_strobes", strb, 33'd0);
        check("idle_rsp", {RSP1_VALID, RSP0_VALID}, 2'b00);
    endtask

    logic [1:0] cont_exp[8];

    initial begin
        // op codes: ADDI=1 SLTI=2 ADD=10 SUB=11 XOR=15 SW=33; 0 and 40 are undefined
        tbl[0] = '{1'b0, 6'd10, 32'd5,      32'd7,      32'd0,          32'd12,     33'd1 << 9};
        tbl[1] = '{1'b1, 6'd11, 32'd10,     32'd3,      32'd0,          32'd7,      33'd1 << 10};
        tbl[2] = '{1'b0, 6'd1,  32'd100,    32'd0,      32'hFFFF_FFFF,  32'd99,     33'd1 << 0};
        tbl[3] = '{1'b1, 6'd15, 32'h0000_F0F0, 32'h0000_0FF0, 32'd0,    32'h0000_FF00, 33'd1 << 14};
        tbl[4] = '{1'b0, 6'd40, 32'd9,      32'd9,      32'd9,          32'd0,      33'd0};
        tbl[5] = '{1'b1, 6'd0,  32'd1,      32'd2,      32'd3,          32'd0,      33'd0};
        tbl[6] = '{1'b0, 6'd33, 32'd4,      32'd4,      32'd4,          32'd0,      33'd1 << 32};
        cont_exp = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};

        do_reset();
        #1;
        check("rst_req_ready", {REQ1_READY, REQ0_READY}, 2'b00);
        check("rst_rsp_valid", {RSP1_VALID, RSP0_VALID}, 2'b00);
        check("rst_strobes", strb, 33'd0);
        check("rst_operands", {ALU_RS1, ALU_RS2}, 64'd0);
        check("rst_result", RSP_RESULT, 32'd0);

        for (int i = 0; i < 7; i++) run_vec(tbl[i]);

        // Contention: round-robin from requester 0, one accept every two cycles
        do_reset();
        @(negedge CLK);
        drive_req(1'b0, 6'd10, 32'd1, 32'd2, 32'd0);
        drive_req(1'b1, 6'd10, 32'd3, 32'd4, 32'd0);
        RSP0_READY = 1'b1; RSP1_READY = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check($sformatf("contention_grant_%0d", i), {REQ1_READY, REQ0_READY}, cont_exp[i]);
            @(negedge CLK);
        end
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        repeat (2) @(negedge CLK);
        RSP0_READY = 1'b0; RSP1_READY = 1'b0;

        // Backpressure on requester 1 with requester 0 waiting
        do_reset();
        @(negedge CLK);
        drive_req(1'b1, 6'd2, 32'hFFFF_FFFF, 32'd0, 32'd0);
        #1;
        check("bp_accept1", REQ1_READY, 1'b1);
        @(negedge CLK);
        REQ1_VALID = 1'b0;
        drive_req(1'b0, 6'd10, 32'd1, 32'd1, 32'd0);
        #1;
        check("bp_exec_ready0", REQ0_READY, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            #1;
            check("bp_hold_valid", RSP1_VALID, 1'b1);
            check("bp_hold_result", RSP_RESULT, 32'd1);
            check("bp_hold_ready0", REQ0_READY, 1'b0);
        end
        RSP1_READY = 1'b1;
        #1;
        check("bp_release_ready0", REQ0_READY, 1'b1);
        @(negedge CLK);
        RSP1_READY = 1'b0; REQ0_VALID = 1'b0;
        #1;
        check("bp_next_strobe", ALU_I_ADD, 1'b1);
        check("bp_rsp1_done", RSP1_VALID, 1'b0);
        @(negedge CLK);
        #1;
        check("bp_next_rsp0", RSP0_VALID, 1'b1);
        check("bp_next_result", RSP_RESULT, 32'd2);
        RSP0_READY = 1'b1;
        @(negedge CLK);
        RSP0_READY = 1'b0;

        // Flush during EXEC, then flush against a pending request
        @(negedge CLK);
        drive_req(1'b0, 6'd10, 32'd3, 32'd4, 32'd0);
        #1;
        check("fl_accept", REQ0_READY, 1'b1);
        @(negedge CLK);
        REQ0_VALID = 1'b0; FLUSH = 1'b1;
        @(negedge CLK);
        FLUSH = 1'b0;
        #1;
        check("fl_no_rsp", {RSP1_VALID, RSP0_VALID}, 2'b00);
        check("fl_idle_strobes", strb, 33'd0);
        FLUSH = 1'b1;
        drive_req(1'b1, 6'd10, 32'd2, 32'd2, 32'd0);
        #1;
        check("fl_pending_blocked", {REQ1_READY, REQ0_READY}, 2'b00);
        @(negedge CLK);
        FLUSH = 1'b0;
        #1;
        check("fl_pending_accept", REQ1_READY, 1'b1);
        @(negedge CLK);
        REQ1_VALID = 1'b0;
        @(negedge CLK);
        #1;
        check("fl_after_rsp", {RSP1_VALID, RSP0_VALID}, 2'b10);
        check("fl_after_result", RSP_RESULT, 32'd4);
        RSP1_READY = 1'b1;
        @(negedge CLK);
        RSP1_READY = 1'b0;

        // Reset while a response is pending drops it and returns priority to requester 0
        @(negedge CLK);
        drive_req(1'b0, 6'd10, 32'd8, 32'd9, 32'd0);
        @(negedge CLK);
        REQ0_VALID = 1'b0;
        @(negedge CLK);
        #1;
        check("rr_pre_valid", RSP0_VALID, 1'b1);
        check("rr_pre_result", RSP_RESULT, 32'd17);
        RST_N = 1'b0;
        @(negedge CLK);
        #1;
        check("rr_rsp_valid", {RSP1_VALID, RSP0_VALID}, 2'b00);
        check("rr_strobes", strb, 33'd0);
        check("rr_operands", {ALU_RS1, ALU_IMM}, 64'd0);
        check("rr_result", RSP_RESULT, 32'd0);
        RST_N = 1'b1;
        drive_req(1'b0, 6'd10, 32'd1, 32'd1, 32'd0);
        drive_req(1'b1, 6'd10, 32'd1, 32'd1, 32'd0);
        #1;
        check("rr_dual_grant0", {REQ1_READY, REQ0_READY}, 2'b01);
        @(negedge CLK);
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        @(negedge CLK);
        RSP0_READY = 1'b1;
        @(negedge CLK);
        RSP0_READY = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
